// File: rtl/ahb_sram_bridge.sv
// AHB-lite slave that turns word transfers into single-port SRAM strobes (one-cycle read latency).
// A write data phase followed by a read costs one wait state; illegal transfers get a two-cycle ERROR.
`timescale 1ns/1ps
module ahb_sram_bridge #(
  parameter int          AW   = 6,
  parameter logic [31:0] BASE = 32'h0000_1000
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [31:0]   haddr,
  input  logic [31:0]   hwdata,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic          hready_in,
  output logic          hready_out,
  output logic [1:0]    hresp,
  output logic [31:0]   hrdata,
  output logic          rd,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic valid;
  logic in_window;
  logic illegal;
  logic bus_rd;
  logic unused_ok;

  assign valid     = hsel & hready_in & htrans[1];
  assign in_window = (haddr[31:AW+2] == BASE[31:AW+2]);
  assign illegal   = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | ~in_window;
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // Only IDLE, WR and RD accept a new address phase; ERR2 drops whatever it samples.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    bus_rd     = 1'b0;
    case (state_q)
      S_RDW:   state_d = S_RD;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: begin
        if (!valid) begin
          state_d = S_IDLE;
        end else if (illegal) begin
          state_d = S_ERR1;
        end else if (hwrite) begin
          state_d    = S_WR;
          lat_addr_d = haddr[AW+1:2];
        end else if (state_q == S_WR) begin
          state_d    = S_RDW;
          lat_addr_d = haddr[AW+1:2];
        end else begin
          state_d = S_RD;
          bus_rd  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rd         = 1'b0;
    we         = 1'b0;
    addr       = addr_q;
    wdata      = wdata_q;
    hready_out = 1'b1;
    hresp      = 2'b00;
    hrdata     = '0;
    case (state_q)
      S_WR: begin
        we    = 1'b1;
        addr  = lat_addr_q;
        wdata = hwdata;
      end
      S_RDW: begin
        rd         = 1'b1;
        addr       = lat_addr_q;
        hready_out = 1'b0;
      end
      S_RD:    hrdata = mem_rdata;
      S_ERR1: begin
        hresp      = 2'b01;
        hready_out = 1'b0;
      end
      S_ERR2:  hresp = 2'b01;
      default: ;
    endcase
    // The read strobe follows the bus directly, but must stay quiet while reset is held.
    if (bus_rd && !hrst) begin
      rd   = 1'b1;
      addr = haddr[AW+1:2];
    end
  end

  assign addr_d  = addr;
  assign wdata_d = wdata;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q    <= S_IDLE;
      lat_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Bench for ahb_sram_bridge: hand sequences, a vector table and random traffic, all checked
// against a transfer-level model of the SRAM window (legality rules, wait-state rule, word store).
`timescale 1ns/1ps
module tb_ahb_sram_bridge;

  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  ERROR = 2'b01;
  localparam logic [1:0]  ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0]  WD = 3'b010, BY = 3'b000;

  logic          hclk = 1'b0;
  logic          hrst;
  logic          hsel;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [31:0]   haddr;
  logic [31:0]   hwdata;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic          hready_out;
  logic [1:0]    hresp;
  logic [31:0]   hrdata;
  logic          rd;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] mem [DEPTH];
  logic        mem_loaded = 1'b0;
  logic [31:0] ref_mem [DEPTH];
  bit          prev_legal_wr;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_waits;
    logic [31:0] exp_rdata;
  } xfer_t;

  xfer_t stim_q[$];
  xfer_t idle_x;
  xfer_t vec [23];

  ahb_sram_bridge #(.AW(AW), .BASE(BASE)) dut (
    .hclk(hclk), .hrst(hrst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready_in(hready_out), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .rd(rd), .we(we), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] init_word(int i);
    return 32'h1000_0000 | 32'(i);
  endfunction

  // Behavioural SRAM with one-cycle read latency; loaded once, never cleared by hrst.
  always @(posedge hclk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (we) mem[addr] <= wdata;
      if (rd) mem_rdata <= mem[addr];
    end
  end

  function automatic xfer_t mk(logic s, logic [1:0] t, logic w, logic [31:0] a, logic [2:0] z,
                               logic [31:0] d, logic e, int ws, logic [31:0] r);
    xfer_t x;
    x.hsel = s; x.htrans = t; x.hwrite = w; x.haddr = a; x.hsize = z; x.wdata = d;
    x.exp_err = e; x.exp_waits = ws; x.exp_rdata = r;
    return x;
  endfunction

  function automatic bit is_valid(xfer_t x);
    return x.hsel && x.htrans[1];
  endfunction

  function automatic bit is_legal(xfer_t x);
    return (x.hsize == 3'b010) && ((x.haddr & 32'd3) == 32'd0) &&
           (x.haddr >= BASE) && (x.haddr < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Transfer-level model: errors cost one wait, a read right after a legal write costs one wait.
  task automatic model_xfer(input xfer_t xi, output xfer_t xo);
    int w;
    xo = xi;
    xo.exp_err = 1'b0; xo.exp_waits = 0; xo.exp_rdata = '0;
    if (!is_valid(xi)) begin
      prev_legal_wr = 1'b0;
    end else if (!is_legal(xi)) begin
      xo.exp_err = 1'b1; xo.exp_waits = 1;
      prev_legal_wr = 1'b0;
    end else begin
      w = word_of(xi.haddr);
      if (xi.hwrite) ref_mem[w] = xi.wdata;
      else begin
        xo.exp_rdata = ref_mem[w];
        xo.exp_waits = prev_legal_wr ? 1 : 0;
      end
      prev_legal_wr = xi.hwrite;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_addr(input xfer_t x);
    hsel   = x.hsel;
    htrans = x.htrans;
    hwrite = x.hwrite;
    haddr  = x.haddr;
    hsize  = x.hsize;
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
  endtask

  // Pipelined AHB master: runs stim_q and checks every cycle against the queued expectations.
  task automatic applyStimulus();
    xfer_t ap, dp;
    bit dp_act, acc, in_wait, exp_rd, exp_we;
    int idx, waits, cycles;
    logic [31:0] exp_addr;
    idx = 0; dp_act = 0; waits = 0; cycles = 0;
    ap = (stim_q.size() > 0) ? stim_q[0] : idle_x;
    dp = idle_x;
    drive_addr(ap);
    while ((idx < stim_q.size() || dp_act) && cycles < 20000) begin
      @(negedge hclk);
      in_wait = dp_act && (waits < dp.exp_waits);
      checkOutput($sformatf("hready_out[%0d]", idx), hready_out, !in_wait);
      checkOutput($sformatf("hresp[%0d]", idx), hresp, (dp_act && dp.exp_err) ? ERROR : OKAY);
      checkOutput($sformatf("hrdata[%0d]", idx), hrdata, (dp_act && !in_wait) ? dp.exp_rdata : 32'h0);
      exp_we = dp_act && is_valid(dp) && is_legal(dp) && dp.hwrite;
      exp_rd = 1'b0;
      exp_addr = '0;
      if (exp_we) exp_addr = 32'(word_of(dp.haddr));
      else if (in_wait && is_valid(dp) && is_legal(dp)) begin
        exp_rd = 1'b1; exp_addr = 32'(word_of(dp.haddr));
      end else if (!in_wait && !(dp_act && dp.exp_err) && is_valid(ap) && is_legal(ap) && !ap.hwrite) begin
        exp_rd = 1'b1; exp_addr = 32'(word_of(ap.haddr));
      end
      checkOutput($sformatf("we[%0d]", idx), we, exp_we);
      checkOutput($sformatf("rd[%0d]", idx), rd, exp_rd);
      if (exp_we || exp_rd) checkOutput($sformatf("addr[%0d]", idx), addr, exp_addr);
      if (exp_we) checkOutput($sformatf("wdata[%0d]", idx), wdata, dp.wdata);
      acc = hready_out;
      @(posedge hclk); #1;
      if (dp_act) begin
        if (acc) dp_act = 1'b0;
        else waits++;
      end
      if (acc && idx < stim_q.size()) begin
        dp = stim_q[idx]; dp_act = 1'b1; waits = 0; idx++;
      end
      hwdata = (dp_act && dp.hwrite) ? dp.wdata : 32'h0;
      ap = (idx < stim_q.size()) ? stim_q[idx] : idle_x;
      drive_addr(ap);
      cycles++;
    end
    if (cycles >= 20000) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL stream_timeout: got %0d cycles, want fewer than 20000", cycles);
    end
    stim_q.delete();
  endtask

  initial begin
    xfer_t x, y;
    idle_x = mk(0, ID, 0, 32'h0, WD, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    prev_legal_wr = 1'b0;

    vec[0]  = mk(1, NS, 1, 32'h1008, WD, 32'hDEAD_BEEF, 0, 0, 32'h0);
    vec[1]  = mk(1, ID, 0, 32'h0,    WD, 32'h0,        0, 0, 32'h0);
    vec[2]  = mk(1, NS, 1, 32'h1004, WD, 32'h1234_5678, 0, 0, 32'h0);
    vec[3]  = mk(1, NS, 0, 32'h1004, WD, 32'h0, 0, 1, 32'h1234_5678);
    vec[4]  = mk(1, NS, 0, 32'h1000, WD, 32'h0, 0, 0, 32'h1000_0000);
    vec[5]  = mk(1, SQ, 0, 32'h1004, WD, 32'h0, 0, 0, 32'h1234_5678);
    vec[6]  = mk(1, SQ, 0, 32'h1008, WD, 32'h0, 0, 0, 32'hDEAD_BEEF);
    vec[7]  = mk(1, SQ, 0, 32'h100C, WD, 32'h0, 0, 0, 32'h1000_0003);
    vec[8]  = mk(1, BZ, 0, 32'h1010, WD, 32'h0, 0, 0, 32'h0);
    vec[9]  = mk(1, NS, 1, 32'h1001, BY, 32'h55,  1, 1, 32'h0);
    vec[10] = idle_x;
    vec[11] = mk(1, NS, 0, 32'h2000, WD, 32'h0, 1, 1, 32'h0);
    vec[12] = idle_x;
    vec[13] = mk(1, NS, 0, 32'h1002, WD, 32'h0, 1, 1, 32'h0);
    vec[14] = idle_x;
    vec[15] = mk(1, NS, 1, 32'h10FC, WD, 32'hAAAA_5555, 0, 0, 32'h0);
    vec[16] = mk(1, NS, 0, 32'h10FC, WD, 32'h0, 0, 1, 32'hAAAA_5555);
    vec[17] = mk(0, NS, 1, 32'h1000, WD, 32'hFFFF_FFFF, 0, 0, 32'h0);
    vec[18] = mk(1, NS, 0, 32'h0FFC, WD, 32'h0, 1, 1, 32'h0);
    vec[19] = idle_x;
    vec[20] = mk(1, NS, 0, 32'h1100, WD, 32'h0, 1, 1, 32'h0);
    vec[21] = idle_x;
    vec[22] = mk(1, NS, 0, 32'h1000, WD, 32'h0, 0, 0, 32'h1000_0000);

    // Reset: outputs at reset values even with a legal read presented on the bus.
    hrst = 1'b1; hwdata = 32'h0;
    drive_addr(mk(1, NS, 0, 32'h1000, WD, 32'h0, 0, 0, 32'h0));
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checkOutput("rst_hready_out", hready_out, 1'b1);
    checkOutput("rst_hresp", hresp, OKAY);
    checkOutput("rst_rd", rd, 1'b0);
    checkOutput("rst_we", we, 1'b0);
    checkOutput("rst_hrdata", hrdata, 32'h0);
    checkOutput("rst_addr", addr, 32'h0);
    checkOutput("rst_wdata", wdata, 32'h0);
    @(posedge hclk); #1;
    hrst = 1'b0;
    drive_addr(idle_x);

    // Single write to 0x1008, then IDLE: strobe one cycle after the address phase, then held values.
    @(posedge hclk); #1;
    x = mk(1, NS, 1, 32'h1008, WD, 32'hDEAD_BEEF, 0, 0, 32'h0);
    model_xfer(x, y);
    drive_addr(x);
    @(negedge hclk);
    checkOutput("wr1_aphase_we", we, 1'b0);
    checkOutput("wr1_aphase_hready", hready_out, 1'b1);
    @(posedge hclk); #1;
    model_xfer(idle_x, y);
    drive_addr(idle_x);
    hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    checkOutput("wr1_dphase_we", we, 1'b1);
    checkOutput("wr1_dphase_rd", rd, 1'b0);
    checkOutput("wr1_dphase_addr", addr, 32'd2);
    checkOutput("wr1_dphase_wdata", wdata, 32'hDEAD_BEEF);
    checkOutput("wr1_dphase_hready", hready_out, 1'b1);
    @(posedge hclk); #1;
    hwdata = 32'h0;
    @(negedge hclk);
    checkOutput("wr1_after_we", we, 1'b0);
    checkOutput("wr1_hold_addr", addr, 32'd2);
    checkOutput("wr1_hold_wdata", wdata, 32'hDEAD_BEEF);
    @(posedge hclk); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 23; i++) begin
      model_xfer(vec[i], y);
      stim_q.push_back(vec[i]);
    end
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      int kind;
      bit bad;
      kind = $urandom_range(0, 99);
      bad = 1'b0;
      x = mk(1, ($urandom_range(0, 1) != 0) ? SQ : NS, 1'($urandom_range(0, 1)),
             BASE + 32'(4 * $urandom_range(0, 7)), WD, $urandom, 0, 0, 32'h0);
      if ($urandom_range(0, 3) == 0) x.haddr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if (kind < 10) begin
        case ($urandom_range(0, 2))
          0:       x.htrans = ID;
          1:       x.htrans = BZ;
          default: x.hsel = 1'b0;
        endcase
      end else if (kind < 20) begin
        bad = 1'b1;
        case ($urandom_range(0, 3))
          0:       x.hsize = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'($urandom_range(0, 1));
          1:       x.haddr = x.haddr + 32'($urandom_range(1, 3));
          2:       x.haddr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
          default: x.haddr = BASE - 32'(4 * $urandom_range(1, 100));
        endcase
      end
      model_xfer(x, y);
      stim_q.push_back(y);
      if (bad) begin
        model_xfer(idle_x, y);
        stim_q.push_back(y);
      end
    end
    applyStimulus();

    // Reset pulsed in the data phase of a write to 0x1010: the write is dropped.
    @(posedge hclk); #1;
    drive_addr(mk(1, NS, 1, 32'h1010, WD, 32'h0, 0, 0, 32'h0));
    @(negedge hclk);
    checkOutput("rstwr_aphase_hready", hready_out, 1'b1);
    @(posedge hclk); #1;
    drive_addr(idle_x);
    hwdata = 32'hBAD0_BAD0;
    @(negedge hclk);
    checkOutput("rstwr_dphase_we", we, 1'b1);
    #2 hrst = 1'b1;
    #1;
    checkOutput("rstwr_we", we, 1'b0);
    checkOutput("rstwr_rd", rd, 1'b0);
    checkOutput("rstwr_hready_out", hready_out, 1'b1);
    checkOutput("rstwr_hresp", hresp, OKAY);
    checkOutput("rstwr_addr", addr, 32'h0);
    checkOutput("rstwr_wdata", wdata, 32'h0);
    @(posedge hclk); #1;
    hrst = 1'b0;
    hwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      checkOutput($sformatf("rstwr_no_we_%0d", i), we, 1'b0);
    end
    checkOutput("rstwr_mem_word", mem[4], ref_mem[4]);
    prev_legal_wr = 1'b0;
    @(posedge hclk); #1;
    model_xfer(mk(1, NS, 0, 32'h1010, WD, 32'h0, 0, 0, 32'h0), y);
    stim_q.push_back(y);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++; n_fail++;
    $display("[TB] FAIL watchdog: got time limit reached, want test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
